// File: rtl/full_adder_8bit.sv
// 8-bit ripple-carry adder with registered sum, carry-out and signed overflow.
// Ports: clk, rst (sync, active-high), a/b/cin in; soma/cout/ovf registered out.
// Build option: FULL_ADDER_8BIT_STICKY_OVF_EN makes ovf sticky until reset.
module full_adder_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] soma,
  output logic       cout,
  output logic       ovf
);

  logic [8:0] c;
  logic [7:0] s;
  logic       ov;

  logic [7:0] soma_q, soma_d;
  logic       cout_q, cout_d;
  logic       ovf_q, ovf_d;

  always_comb begin
    c    = 9'd0;
    s    = 8'd0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  // Carry into the sign bit differing from carry out means signed overflow.
  assign ov = c[7] ^ c[8];

  always_comb begin
    soma_d = s;
    cout_d = c[8];
`ifdef FULL_ADDER_8BIT_STICKY_OVF_EN
    ovf_d  = ovf_q | ov;
`else
    ovf_d  = ov;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      soma_q <= 8'h00;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      soma_q <= soma_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign soma = soma_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_full_adder_8bit.sv
// Self-checking bench for full_adder_8bit: directed table plus random
// vectors against an arithmetic reference model.
module tb_full_adder_8bit;

`ifdef FULL_ADDER_8BIT_STICKY_OVF_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic       cin;
  logic [7:0] soma;
  logic       cout, ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  full_adder_8bit dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .soma (soma),
    .cout (cout),
    .ovf  (ovf)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] e_soma;
    logic       e_cout;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [7:0] va,
                       input logic [7:0] vb, input logic vc);
    rst = r;
    a   = va;
    b   = vb;
    cin = vc;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  logic stk;
  task automatic model(input logic r, input logic [7:0] va,
                       input logic [7:0] vb, input logic vc,
                       output logic [7:0] es, output logic ec,
                       output logic eo);
    int u, sg;
    bit ov;
    u  = int'(va) + int'(vb) + int'(vc);
    sg = int'($signed(va)) + int'($signed(vb)) + int'(vc);
    ov = (sg > 127) || (sg < -128);
    if (r) begin
      es  = 8'h00;
      ec  = 1'b0;
      stk = 1'b0;
    end else begin
      es  = u[7:0];
      ec  = (u > 255);
      stk = STICKY ? (stk | ov) : ov;
    end
    eo = stk;
  endtask

  initial begin
    vec_t v;
    logic [7:0] es, hs;
    logic ec, eo, hc, ho;
    rst = 1'b1; a = '0; b = '0; cin = 1'b0;

    tbl.push_back('{"reset", 1, 8'hFF, 8'hFF, 1, 8'h00, 0, 0});
    tbl.push_back('{"d91+42", 0, 8'h91, 8'h42, 0, 8'hD3, 0, 0});
    tbl.push_back('{"dFF+01", 0, 8'hFF, 8'h01, 0, 8'h00, 1, 0});
    tbl.push_back('{"d1B+25c", 0, 8'h1B, 8'h25, 1, 8'h41, 0, 0});
    tbl.push_back('{"dFE+01c", 0, 8'hFE, 8'h01, 1, 8'h00, 1, 0});
    tbl.push_back('{"o7F+01", 0, 8'h7F, 8'h01, 0, 8'h80, 0, 1});
    tbl.push_back('{"o80+80", 0, 8'h80, 8'h80, 0, 8'h00, 1, 1});
    tbl.push_back('{"s7F+01", 0, 8'h7F, 8'h01, 0, 8'h80, 0, 1});
    tbl.push_back('{"s01+01", 0, 8'h01, 8'h01, 0, 8'h02, 0, STICKY});
    tbl.push_back('{"sclr", 1, 8'h7F, 8'h01, 0, 8'h00, 0, 0});
    tbl.push_back('{"first", 0, 8'h10, 8'h20, 1, 8'h31, 0, 0});
    tbl.push_back('{"rclr", 1, 8'h00, 8'h00, 0, 8'h00, 0, 0});

    foreach (tbl[i]) begin
      v = tbl[i];
      apply(v.rst, v.a, v.b, v.cin);
      chk({v.name, ".soma"}, soma, v.e_soma);
      chk({v.name, ".cout"}, {7'd0, cout}, {7'd0, v.e_cout});
      chk({v.name, ".ovf"}, {7'd0, ovf}, {7'd0, v.e_ovf});
    end

    // Outputs must hold while inputs change between edges.
    apply(1'b0, 8'h7F, 8'h7F, 1'b1);
    hs = soma; hc = cout; ho = ovf;
    chk("hold.load", soma, 8'hFF);
    a = 8'h00; b = 8'h01; cin = 1'b0;
    #3;
    chk("hold.soma", soma, hs);
    chk("hold.flags", {6'd0, cout, ovf}, {6'd0, hc, ho});

    apply(1'b1, 8'h00, 8'h00, 1'b0);
    stk = 1'b0;

    for (int i = 0; i < 256; i++) begin
      logic r;
      logic [7:0] ra, rb;
      logic rc;
      r  = (i == 100) || (i == 200);
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      model(r, ra, rb, rc, es, ec, eo);
      apply(r, ra, rb, rc);
      chk(r ? "mrst.soma" : "rnd.soma", soma, es);
      chk(r ? "mrst.cout" : "rnd.cout", {7'd0, cout}, {7'd0, ec});
      chk(r ? "mrst.ovf" : "rnd.ovf", {7'd0, ovf}, {7'd0, eo});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/full_adder_8bit.md
FULL_ADDER_8BIT -- requirements
Module: full_adder_8bit

Interface
REQ-001 Parameters: none; the datapath width SHALL be fixed at 8 bits.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset, sampled on the rising clk edge.
REQ-005 Port a, input, 8 bits: addend A, unsigned or two's complement.
REQ-006 Port b, input, 8 bits: addend B, unsigned or two's complement.
REQ-007 Port cin, input, 1 bit: carry into bit 0.
REQ-008 Port soma, output, 8 bits: registered sum bits [7:0].
REQ-009 Port cout, output, 1 bit: registered carry out of bit 7, which is the unsigned overflow.
REQ-010 Port ovf, output, 1 bit: registered two's-complement overflow flag.

Function
REQ-011 Combinational core: {c8, s[7:0]} SHALL equal a + b + cin, computed as a ripple chain of eight 1-bit full-adder stages (s_i = a_i^b_i^c_i; c_{i+1} = a_i&b_i | c_i&(a_i^b_i); c_0 = cin).
REQ-012 Signed overflow SHALL be ov = c7 ^ c8, where c7 is the carry into bit 7; this is equivalent to operands of equal sign producing a sum of the opposite sign.
REQ-013 On each rising clk with rst=0, the block SHALL load soma<=s, cout<=c8 and ovf<=ov (or the sticky variant, REQ-022).
REQ-014 Latency SHALL be exactly 1 cycle: inputs present before edge N SHALL appear on the outputs after edge N.
REQ-015 Throughput SHALL be one new operation per cycle; there is no handshake and no state machine.
REQ-016 Outputs SHALL hold their value between edges regardless of input changes.
REQ-017 Wrap-around: sums at or above 256 SHALL wrap modulo 256 in soma, with cout=1.
REQ-018 cout and ovf SHALL be independent: either, both or neither may be set.

Reset
REQ-019 When rst=1 at a rising edge, soma SHALL become 8'h00, cout 0 and ovf 0, ignoring a, b and cin.
REQ-020 Reset SHALL take priority over loading; an operation whose edge coincides with rst=1 SHALL be discarded.
REQ-021 The first edge with rst=0 after reset SHALL load normally.

Configuration
REQ-022 With macro FULL_ADDER_8BIT_STICKY_OVF_EN defined, ovf SHALL be sticky (ovf <= ovf | ov) and clear only on reset.
REQ-023 Without FULL_ADDER_8BIT_STICKY_OVF_EN, ovf SHALL reflect only the current operation (ovf <= ov).
REQ-024 The macro SHALL NOT change soma, cout, ports or latency.

Verification
REQ-025 Reset check: rst=1 for one edge with a=8'hFF, b=8'hFF, cin=1 -> soma=8'h00, cout=0, ovf=0.
REQ-026 Directed sums with rst=0, each checked one cycle later:
- a=8'h91, b=8'h42, cin=0 -> soma=8'hD3, cout=0, ovf=0.
- a=8'hFF, b=8'h01, cin=0 -> soma=8'h00, cout=1, ovf=0.
- a=8'h1B, b=8'h25, cin=1 -> soma=8'h41, cout=0, ovf=0.
- a=8'hFE, b=8'h01, cin=1 -> soma=8'h00, cout=1, ovf=0.
REQ-027 Signed overflow cases:
- a=8'h7F, b=8'h01, cin=0 -> soma=8'h80, cout=0, ovf=1.
- a=8'h80, b=8'h80, cin=0 -> soma=8'h00, cout=1, ovf=1.
REQ-028 Sticky check: apply a=8'h7F, b=8'h01, then a=8'h01, b=8'h01 -> ovf=0 on the second result without the macro, ovf=1 with it; rst=1 then clears ovf to 0.
REQ-029 Back-to-back and mid-stream reset:
- Change inputs on every edge for 256 random vectors; compare each result against a+b+cin one cycle later.
- Assert rst mid-stream; outputs SHALL be zero on the following cycle.
